// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS datapath widths and the writeback queue entry type.
//               REG_ADDR_W / DATA_W : register address and data widths.
//               ZERO_REG            : hard-wired zero register, never written.
//               wb_entry_t          : {valid, regAddr, data} queue slot.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] regAddr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/wb_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : wb_fwd_match
// Description : Priority match of one probe address against every queue slot.
//               Slots are scanned oldest (head) to newest, so the last valid
//               match wins and the newest pending value is forwarded.
//               A probe of register 0 never hits.
// Ports       : i_entries - all queue slots
//               i_head    - index of the oldest slot
//               i_probe   - register address being read by decode
//               o_hit     - a valid slot holds i_probe
//               o_data    - newest matching data, 0 on a miss
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fwd_match
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  wb_entry_t             i_entries [DEPTH],
    input  logic [PTRW-1:0]       i_head,
    input  logic [REG_ADDR_W-1:0] i_probe,
    output logic                  o_hit,
    output logic [DATA_W-1:0]     o_data
);

    // Slots rotated so that index 0 is the oldest entry.
    wb_entry_t w_ordered [DEPTH];

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_rotate
            logic [PTRW-1:0] w_idx;
            assign w_idx        = i_head + PTRW'(k);
            assign w_ordered[k] = i_entries[w_idx];
        end
    endgenerate

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ordered[i].valid && (w_ordered[i].regAddr == i_probe) &&
                (i_probe != ZERO_REG)) begin
                o_hit  = 1'b1;
                o_data = w_ordered[i].data;
            end
        end
    end

endmodule : wb_fwd_match
`default_nettype wire

// File: rtl/wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_queue
// Description : In-order writeback buffer in front of the register file write
//               port, with read-after-write forwarding for two read ports.
// Ports       : Clk, Reset_n          - clock, async active-low reset
//               InValid/InReady       - enqueue handshake
//               InRegister/InData     - write request (reg 0 accepted, dropped)
//               Hold                  - suppress draining this cycle
//               Flush                 - discard all entries, kill enqueue
//               WriteRegister/WriteData/RegWrite - register file write port
//               ReadRegister1/2       - decode read addresses
//               Fwd1Hit/Fwd1Data, Fwd2Hit/Fwd2Data - forwarding results
//               Count                 - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module wb_write_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [REG_ADDR_W-1:0] InRegister,
    input  logic [DATA_W-1:0]     InData,
    input  logic                  Hold,
    input  logic                  Flush,
    output logic [REG_ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0]     WriteData,
    output logic                  RegWrite,
    input  logic [REG_ADDR_W-1:0] ReadRegister1,
    input  logic [REG_ADDR_W-1:0] ReadRegister2,
    output logic                  Fwd1Hit,
    output logic [DATA_W-1:0]     Fwd1Data,
    output logic                  Fwd2Hit,
    output logic [DATA_W-1:0]     Fwd2Data,
    output logic [PTRW:0]         Count
);

    localparam logic [PTRW:0] c_FULL_COUNT = (PTRW+1)'(DEPTH);

    wb_entry_t       r_entries [DEPTH];
    logic [PTRW-1:0] r_head;
    logic [PTRW-1:0] r_tail;
    logic [PTRW:0]   r_count;

    logic w_notEmpty;
    logic w_accept;
    logic w_push;
    logic w_pop;

    // Ready depends only on registered occupancy: no combinational ready path.
    assign InReady    = (r_count != c_FULL_COUNT);
    assign w_notEmpty = (r_count != '0);

    // Handshake completes for register 0, but nothing is stored.
    assign w_accept = InValid && InReady && !Flush;
    assign w_push   = w_accept && (InRegister != ZERO_REG);

    assign RegWrite      = w_notEmpty && !Hold && !Flush;
    assign w_pop         = RegWrite;
    assign WriteRegister = w_notEmpty ? r_entries[r_head].regAddr : '0;
    assign WriteData     = w_notEmpty ? r_entries[r_head].data    : '0;
    assign Count         = r_count;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else if (Flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].valid <= 1'b0;
            end
        end else begin
            // Push and pop never target the same slot: pushing into the head
            // slot requires an empty queue, which cannot pop.
            if (w_pop) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + PTRW'(1);
            end
            if (w_push) begin
                r_entries[r_tail] <= '{valid: 1'b1, regAddr: InRegister, data: InData};
                r_tail            <= r_tail + PTRW'(1);
            end
            r_count <= r_count + (PTRW+1)'(w_push) - (PTRW+1)'(w_pop);
        end
    end

    // The head entry being committed stays visible to forwarding, since the
    // register file only shows the new value after this edge.
    wb_fwd_match #(
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) u_fwd1 (
        .i_entries (r_entries),
        .i_head    (r_head),
        .i_probe   (ReadRegister1),
        .o_hit     (Fwd1Hit),
        .o_data    (Fwd1Data)
    );

    wb_fwd_match #(
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) u_fwd2 (
        .i_entries (r_entries),
        .i_head    (r_head),
        .i_probe   (ReadRegister2),
        .o_hit     (Fwd2Hit),
        .o_data    (Fwd2Data)
    );

endmodule : wb_write_queue
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_write_queue
// Description : Directed self-checking bench for wb_write_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_write_queue;
    import mips_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTRW  = 2;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        InValid;
    logic        InReady;
    logic [4:0]  InRegister;
    logic [31:0] InData;
    logic        Hold;
    logic        Flush;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic        Fwd1Hit;
    logic [31:0] Fwd1Data;
    logic        Fwd2Hit;
    logic [31:0] Fwd2Data;
    logic [PTRW:0] Count;

    int checkCount = 0;
    int failCount  = 0;

    always #5 Clk = ~Clk;

    wb_write_queue #(
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .InValid       (InValid),
        .InReady       (InReady),
        .InRegister    (InRegister),
        .InData        (InData),
        .Hold          (Hold),
        .Flush         (Flush),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .Fwd1Hit       (Fwd1Hit),
        .Fwd1Data      (Fwd1Data),
        .Fwd2Hit       (Fwd2Hit),
        .Fwd2Data      (Fwd2Data),
        .Count         (Count)
    );

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic enq(input logic [4:0] r, input logic [31:0] d);
        InValid    = 1'b1;
        InRegister = r;
        InData     = d;
        step();
        InValid    = 1'b0;
    endtask

    logic [4:0]  expReg  [4];
    logic [31:0] expData [4];
    logic [4:0]  sbReg   [$];
    logic [31:0] sbData  [$];
    int          sent;
    int          committed;
    logic        expRw;
    logic        expReady;

    initial begin
        Reset_n       = 1'b0;
        InValid       = 1'b0;
        InRegister    = '0;
        InData        = '0;
        Hold          = 1'b0;
        Flush         = 1'b0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;

        // ---------------- reset values ----------------
        #3;
        checkEq("rst_inready",  InReady, 1);
        checkEq("rst_regwrite", RegWrite, 0);
        checkEq("rst_count",    Count, 0);
        checkEq("rst_wreg",     WriteRegister, 0);
        checkEq("rst_wdata",    WriteData, 0);
        checkEq("rst_fwd1hit",  Fwd1Hit, 0);
        checkEq("rst_fwd2data", Fwd2Data, 0);
        step();
        step();
        Reset_n = 1'b1;
        step();

        // ---------------- single write, 1-cycle latency ----------------
        ReadRegister1 = 5'd5;
        enq(5'd5, 32'hDEADBEEF);
        #1;
        checkEq("single_regwrite", RegWrite, 1);
        checkEq("single_wreg",     WriteRegister, 5);
        checkEq("single_wdata",    WriteData, 32'hDEADBEEF);
        checkEq("single_count",    Count, 1);
        checkEq("single_fwdhit",   Fwd1Hit, 1);
        checkEq("single_fwddata",  Fwd1Data, 32'hDEADBEEF);
        step();
        #1;
        checkEq("single_count_after", Count, 0);
        checkEq("single_rw_after",    RegWrite, 0);

        // ---------------- fill while held ----------------
        Hold = 1'b1;
        enq(5'd3, 32'h11);
        enq(5'd3, 32'h22);
        enq(5'd7, 32'h33);
        enq(5'd9, 32'h44);
        InValid    = 1'b1;
        InRegister = 5'd11;
        InData     = 32'h99;
        #1;
        checkEq("full_inready", InReady, 0);
        checkEq("full_count",   Count, 4);
        checkEq("full_hold_rw", RegWrite, 0);
        step();
        InValid = 1'b0;
        #1;
        checkEq("full_refused_count", Count, 4);
        ReadRegister1 = 5'd3;
        ReadRegister2 = 5'd8;
        #1;
        checkEq("fwd_dup_hit",   Fwd1Hit, 1);
        checkEq("fwd_dup_data",  Fwd1Data, 32'h22);
        checkEq("fwd_miss_hit",  Fwd2Hit, 0);
        checkEq("fwd_miss_data", Fwd2Data, 0);
        ReadRegister2 = 5'd9;
        #1;
        checkEq("fwd_tail_data", Fwd2Data, 32'h44);

        // ---------------- in-order drain ----------------
        expReg[0] = 5'd3; expData[0] = 32'h11;
        expReg[1] = 5'd3; expData[1] = 32'h22;
        expReg[2] = 5'd7; expData[2] = 32'h33;
        expReg[3] = 5'd9; expData[3] = 32'h44;
        Hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkEq($sformatf("drain%0d_rw", i),   RegWrite, 1);
            checkEq($sformatf("drain%0d_reg", i),  WriteRegister, expReg[i]);
            checkEq($sformatf("drain%0d_data", i), WriteData, expData[i]);
            if (i == 0) begin
                checkEq("drain0_fwd_data", Fwd1Data, 32'h22);
            end
            step();
        end
        #1;
        checkEq("drain_empty_count", Count, 0);
        checkEq("drain_empty_rw",    RegWrite, 0);

        // ---------------- register 0 ----------------
        ReadRegister1 = 5'd0;
        InValid       = 1'b1;
        InRegister    = 5'd0;
        InData        = 32'hFFFFFFFF;
        #1;
        checkEq("zero_inready", InReady, 1);
        step();
        InValid = 1'b0;
        #1;
        checkEq("zero_count",  Count, 0);
        checkEq("zero_rw",     RegWrite, 0);
        checkEq("zero_fwdhit", Fwd1Hit, 0);

        // ---------------- flush with concurrent enqueue ----------------
        Hold = 1'b1;
        enq(5'd1, 32'h1);
        enq(5'd2, 32'h2);
        enq(5'd6, 32'h6);
        Hold          = 1'b0;
        Flush         = 1'b1;
        InValid       = 1'b1;
        InRegister    = 5'd4;
        InData        = 32'h55;
        ReadRegister2 = 5'd2;
        #1;
        checkEq("flush_cycle_rw",      RegWrite, 0);
        checkEq("flush_cycle_inready", InReady, 1);
        checkEq("flush_cycle_count",   Count, 3);
        checkEq("flush_cycle_fwdhit",  Fwd2Hit, 1);
        checkEq("flush_cycle_fwddata", Fwd2Data, 32'h2);
        step();
        Flush         = 1'b0;
        InValid       = 1'b0;
        ReadRegister1 = 5'd4;
        #1;
        checkEq("flush_count",   Count, 0);
        checkEq("flush_rw",      RegWrite, 0);
        checkEq("flush_fwd4",    Fwd1Hit, 0);
        step();
        #1;
        checkEq("flush_rw_later", RegWrite, 0);

        // ---------------- streaming with wrap ----------------
        sent      = 0;
        committed = 0;
        for (int cyc = 0; cyc < 60 && committed < 10; cyc++) begin
            Hold       = (cyc % 2) == 1;
            InValid    = (sent < 10);
            InRegister = 5'(sent + 1);
            InData     = 32'h1000 + 32'(sent) * 32'h11;
            #1;
            expReady = (sbReg.size() != DEPTH);
            expRw    = (sbReg.size() != 0) && !Hold;
            checkEq("stream_count",   Count, 32'(sbReg.size()));
            checkEq("stream_inready", InReady, expReady);
            checkEq("stream_rw",      RegWrite, expRw);
            if (expRw) begin
                checkEq("stream_wreg",  WriteRegister, sbReg[0]);
                checkEq("stream_wdata", WriteData, sbData[0]);
                void'(sbReg.pop_front());
                void'(sbData.pop_front());
                committed++;
            end
            if (InValid && expReady) begin
                sbReg.push_back(InRegister);
                sbData.push_back(InData);
                sent++;
            end
            step();
        end
        InValid = 1'b0;
        Hold    = 1'b0;
        checkEq("stream_committed", committed, 10);

        // ---------------- asynchronous reset mid-stream ----------------
        Hold = 1'b1;
        enq(5'd12, 32'hAAAA);
        enq(5'd13, 32'hBBBB);
        Hold          = 1'b0;
        ReadRegister1 = 5'd12;
        #1;
        checkEq("prereset_rw",     RegWrite, 1);
        checkEq("prereset_fwdhit", Fwd1Hit, 1);
        Reset_n = 1'b0;
        #1;
        checkEq("areset_rw",       RegWrite, 0);
        checkEq("areset_count",    Count, 0);
        checkEq("areset_inready",  InReady, 1);
        checkEq("areset_wreg",     WriteRegister, 0);
        checkEq("areset_wdata",    WriteData, 0);
        checkEq("areset_fwd1hit",  Fwd1Hit, 0);
        checkEq("areset_fwd1data", Fwd1Data, 0);
        step();
        Reset_n = 1'b1;
        step();
        #1;
        checkEq("postreset_rw",    RegWrite, 0);
        checkEq("postreset_count", Count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule : tb_wb_write_queue
`default_nettype wire

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Writeback buffer directly upstream of the MIPS register file's write port.
- Accepts register-write requests from the execute/memory stages with a valid/ready handshake and queues them in order.
- Drains at most one entry per cycle into the register file as WriteRegister/WriteData/RegWrite.
- Provides read-after-write forwarding for both read addresses, so decode sees queued but not-yet-committed values.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16.
- PTRW, 2, pointer width; equals log2(DEPTH).

Ports:
- Clk  input  1  clock, positive edge.
- Reset_n  input  1  asynchronous, active-low reset.
- InValid  input  1  producer has a write request.
- InReady  output  1  queue can accept this cycle.
- InRegister  input  5  destination register address.
- InData  input  32  value to write.
- Hold  input  1  when high, suppress draining this cycle (write port borrowed or pipeline stall).
- Flush  input  1  discard all queued entries.
- WriteRegister  output  5  to regfile WriteRegister.
- WriteData  output  32  to regfile WriteData.
- RegWrite  output  1  to regfile RegWrite.
- ReadRegister1  input  5  probe address, same as the regfile's ReadRegister1.
- ReadRegister2  input  5  probe address, same as the regfile's ReadRegister2.
- Fwd1Hit  output  1  a queued entry matches ReadRegister1.
- Fwd1Data  output  32  newest matching data for ReadRegister1.
- Fwd2Hit  output  1  a queued entry matches ReadRegister2.
- Fwd2Data  output  32  newest matching data for ReadRegister2.
- Count  output  PTRW+1  occupancy.

Behaviour:
- Clock and reset: one clock, Clk, positive edge. Reset_n is asynchronous and active-low.
- Reset: head, tail and Count go to 0; all entry valid bits clear. RegWrite=0, WriteRegister=0, WriteData=0, Fwd*Hit=0, Fwd*Data=0, InReady=1.
- Storage: circular buffer with head/tail pointers that wrap modulo DEPTH. Count is registered.
- InReady: equals (Count != DEPTH). It does not depend on same-cycle drain, so there is no combinational ready path.
- Enqueue: occurs on a Clk edge when InValid && InReady && !Flush.
  - Address 0 is accepted (handshake completes) but not stored, so Count is unchanged. Register 0 is never written or forwarded.
- Drain outputs are combinational from the head entry:
  - RegWrite = (Count != 0) && !Hold && !Flush.
  - WriteRegister/WriteData are the head entry's fields when Count != 0, else 0.
- Commit: the regfile captures the head entry on the same edge the queue pops it. Write latency is 1 cycle minimum from enqueue, or more while Hold is asserted or earlier entries are pending.
- Simultaneous enqueue and drain: Count is unchanged and both pointers advance. When full, the drain still happens, but the enqueue is refused because InReady=0 that cycle.
- Flush: on the edge, head=tail=0 and Count=0. A same-cycle enqueue is dropped even though InReady=1; producers must treat Flush as a kill. RegWrite is forced to 0 in the Flush cycle.
- Forwarding: combinational over all valid entries.
  - The hit is the newest entry (closest to tail) whose register equals ReadRegisterN, and ReadRegisterN != 0.
  - The head entry being committed this cycle is still included. The regfile read is asynchronous and shows the old value until the edge.
  - On a miss, FwdNData=0.
  - Flush does not gate forwarding within its own cycle.
- Ordering: entries commit strictly in enqueue order. Duplicate destinations are all committed, so the last write wins in the regfile.
- Reset mid-operation: all pending writes are lost and no RegWrite pulse is emitted after Reset_n deasserts until a new enqueue.

Decomposition:
- Shared package (mips_pkg): REG_ADDR_W=5, DATA_W=32, ZERO_REG=5'd0, and a struct or typedef wb_entry_t {valid, reg[4:0], data[31:0]}.
- One sub-module, wb_fwd_match: a priority match of one probe address over DEPTH entries, ordered oldest to newest relative to head. It is instantiated twice, for ports 1 and 2.

Test Plan:
- Reset, then enqueue (5, 0xDEADBEEF) with Hold=0 → next cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF; the cycle after, Count=0 and RegWrite=0.
- Hold=1; enqueue (3,0x11), (3,0x22), (7,0x33), (9,0x44); fifth InValid → InReady=0 and Count=4.
  - ReadRegister1=3 → Fwd1Hit=1, Fwd1Data=0x22.
  - ReadRegister2=8 → Fwd2Hit=0, Fwd2Data=0.
- Release Hold with the queue full → commits in order 3/0x11, 3/0x22, 7/0x33, 9/0x44 on consecutive edges.
  - During the first commit, Fwd1Data for reg 3 stays 0x22.
- Enqueue (0, 0xFFFFFFFF) → handshake completes, Count stays 0, no RegWrite; probe reg 0 → Fwd1Hit=0.
- With 3 entries held, assert Flush together with InValid (4,0x55) → next cycle Count=0, no RegWrite for any of the 4 values, Fwd hit on reg 4 = 0.
- Wrap and reset:
  - Stream 10 enqueues with Hold toggling every other cycle → all 10 commit in order; pointer wrap verified against a scoreboard.
  - Assert Reset_n=0 mid-stream → outputs go to reset values immediately, without waiting for a clock edge.
